// File: rtl/ram_be_clr_if.sv
// ram_be_clr_if: bus bundle for ram_be_clr (clear request/busy, byte-enabled write port, registered read port)
// master drives clr/we/be/wadr/din/re/radr; slave drives busy/dout/dvalid
// RAM_PARITY_EN adds perr_inj (master) and perr (slave)
interface ram_be_clr_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;
  logic clr, busy, we, re, dvalid;
  logic [NB-1:0] be;
  logic [ADDR_W-1:0] wadr, radr;
  logic [DATA_W-1:0] din, dout;
`ifdef RAM_PARITY_EN
  logic perr_inj, perr;
  modport master(output clr, we, be, wadr, din, re, radr, perr_inj, input busy, dout, dvalid, perr);
  modport slave(input clr, we, be, wadr, din, re, radr, perr_inj, output busy, dout, dvalid, perr);
`else
  modport master(output clr, we, be, wadr, din, re, radr, input busy, dout, dvalid);
  modport slave(input clr, we, be, wadr, din, re, radr, output busy, dout, dvalid);
`endif
endinterface

// File: rtl/ram_be_clr.sv
// ram_be_clr: simple dual-port RAM with byte enables, registered write-first read and a clear engine
// ports: clk, rst (sync active-high), bus (ram_be_clr_if.slave: clr/busy, we/be/wadr/din, re/radr/dout/dvalid)
// RAM_PARITY_EN: per-byte even parity storage, perr_inj on writes, perr flagged alongside dvalid
module ram_be_clr #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input logic clk,
  input logic rst,
  ram_be_clr_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd;
  logic idle, hit;
  assign idle = state == IDLE;
  assign hit = idle && bus.we && bus.wadr == bus.radr;
  assign bus.busy = !idle;
`ifdef RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] clr_par, wpar, rpar, rd_par;
`endif
  // read data is merged with the same-cycle write per byte (write-first)
  genvar g;
  for (g = 0; g < NB; g++) begin : g_lane
    assign rd[8*g+:8] = hit && bus.be[g] ? bus.din[8*g+:8] : mem[bus.radr][8*g+:8];
`ifdef RAM_PARITY_EN
    assign clr_par[g] = ^CLR_VAL[8*g+:8];
    assign wpar[g] = ^bus.din[8*g+:8] ^ bus.perr_inj;
    assign rpar[g] = hit && bus.be[g] ? wpar[g] : par[bus.radr][g];
    assign rd_par[g] = ^rd[8*g+:8];
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst && !idle) begin
      mem[cnt] <= CLR_VAL;
`ifdef RAM_PARITY_EN
      par[cnt] <= clr_par;
`endif
    end else if (!rst && bus.we) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.be[i]) begin
          mem[bus.wadr][8*i+:8] <= bus.din[8*i+:8];
`ifdef RAM_PARITY_EN
          par[bus.wadr][i] <= wpar[i];
`endif
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      bus.dout <= '0;
      bus.dvalid <= 1'b0;
`ifdef RAM_PARITY_EN
      bus.perr <= 1'b0;
`endif
    end else begin
      bus.dvalid <= idle && bus.re;
      if (idle && bus.re) bus.dout <= rd;
`ifdef RAM_PARITY_EN
      bus.perr <= idle && bus.re && |(rpar ^ rd_par);
`endif
      if (!idle) begin
        cnt <= cnt + 1'b1;
        if (&cnt) state <= IDLE;
      end else if (bus.clr) begin
        state <= CLEAR;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ram_be_clr.sv
// tb_ram_be_clr: randomized scoreboard bench for ram_be_clr against an array-level reference model
module tb_ram_be_clr;
  localparam logic [31:0] CV = 32'hA5C3_0F96;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ram_be_clr_if #(.ADDR_W(4), .DATA_W(32)) bus();
  ram_be_clr #(.ADDR_W(4), .DATA_W(32), .CLR_VAL(CV)) dut(.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] model [16];
  logic [3:0] bad [16];
  logic [31:0] exp_q [$];
  logic perr_q [$];
  int clr_rem = 16;
  logic exp_dv = 1'b0;
  logic mon_en = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] e;
  logic p;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic wipe();
    for (int i = 0; i < 16; i++) begin
      model[i] = CV;
      bad[i] = 4'h0;
    end
  endtask
  task automatic cyc(input logic w, input logic [3:0] b, input logic [3:0] wa, input logic [31:0] d,
                     input logic r, input logic [3:0] ra, input logic c, input logic inj);
    int nrem;
    logic ndv;
    bus.we = w;
    bus.be = b;
    bus.wadr = wa;
    bus.din = d;
    bus.re = r;
    bus.radr = ra;
    bus.clr = c;
`ifdef RAM_PARITY_EN
    bus.perr_inj = inj;
`endif
    ndv = 1'b0;
    nrem = clr_rem;
    if (rst) begin
      nrem = 16;
      wipe();
    end else if (clr_rem > 0) nrem = clr_rem - 1;
    else begin
      if (w) for (int i = 0; i < 4; i++) if (b[i]) begin
        model[wa][8*i+:8] = d[8*i+:8];
        bad[wa][i] = inj;
      end
      if (r) begin
        exp_q.push_back(model[ra]);
        perr_q.push_back(|bad[ra]);
        ndv = 1'b1;
      end
      if (c) begin
        nrem = 16;
        wipe();
      end
    end
    @(posedge clk);
    #1;
    clr_rem = nrem;
    exp_dv = ndv;
  endtask
  task automatic idle();
    cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b, input logic inj);
    cyc(1'b1, b, a, d, 1'b0, 4'h0, 1'b0, inj);
  endtask
  task automatic rd(input logic [3:0] a);
    cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a, 1'b0, 1'b0);
  endtask
  task automatic busy_len(input string nm);
    int n;
    logic [31:0] x;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      x = $urandom;
      cyc(x[4], x[3:0], x[7:4], x, 1'b1, x[11:8], x[12], 1'b0);
      n++;
    end
    check(nm, n, 16);
  endtask
  always @(negedge clk) if (mon_en) begin
    check("busy", {31'b0, bus.busy}, {31'b0, clr_rem > 0});
    check("dvalid", {31'b0, bus.dvalid}, {31'b0, exp_dv});
    if (bus.dvalid === 1'b1) begin
      if (exp_q.size() == 0) check("dvalid_unexpected", {31'b0, bus.dvalid}, 32'h0);
      else begin
        e = exp_q.pop_front();
        p = perr_q.pop_front();
        check("dout", bus.dout, e);
`ifdef RAM_PARITY_EN
        check("perr", {31'b0, bus.perr}, {31'b0, p});
`endif
      end
    end
`ifdef RAM_PARITY_EN
    else check("perr_idle", {31'b0, bus.perr}, 32'h0);
`endif
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] x, y;
    wipe();
    idle();
    mon_en = 1'b1;
    idle();
    check("rst_dout", bus.dout, 32'h0);
    check("rst_dvalid", {31'b0, bus.dvalid}, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h1);
    rst = 1'b0;
    busy_len("busy_after_reset");
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle();
    wr(4'h1, 32'h0000_000A, 4'hF, 1'b0);
    rd(4'h1);
    idle();
    idle();
    wr(4'hF, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr(4'hF, 32'h1234_5678, 4'h5, 1'b0);
    rd(4'hF);
    idle();
    wr(4'h8, 32'h0000_FFFF, 4'hF, 1'b0);
    cyc(1'b1, 4'h3, 4'h8, 32'hAABB_CCDD, 1'b1, 4'h8, 1'b0, 1'b0);
    idle();
    rd(4'h8);
    idle();
    for (int a = 0; a < 6; a++) wr(4'(a), $urandom, 4'hF, 1'b0);
    cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b1, 4'hF, 4'h2, 32'h0000_0055, 1'b1, 4'h2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i), 1'b1, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    busy_len("busy_after_midclear_rst");
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle();
`ifdef RAM_PARITY_EN
    wr(4'h3, 32'h0000_0001, 4'hF, 1'b1);
    rd(4'h3);
    wr(4'h3, 32'h0000_0001, 4'hF, 1'b0);
    rd(4'h3);
    cyc(1'b1, 4'h2, 4'h5, 32'h1357_9BDF, 1'b1, 4'h5, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    busy_len("busy_after_clr");
    rd(4'h3);
    rd(4'h5);
    idle();
`endif
    repeat (400) begin
      x = $urandom;
      y = $urandom;
      if (x[31:26] == 6'h0)
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
      else
        cyc(x[0], x[4:1], x[8:5], y, x[9], x[13:10], 1'b0, x[14] & x[15]);
    end
    for (int i = 0; i < 20; i++) idle();
    check("queue_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
